// File: rtl/boot_sequencer_pkg.sv
// Shared widths, FSM encodings and status bit positions for the rv32i boot sequencer.
package boot_sequencer_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 10;
    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned I_BRAM_DEPTH   = 256;
    localparam int unsigned CNT_W          = 9;
    localparam int unsigned CYC_W          = 32;
    localparam int unsigned STATE_W        = 3;

    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_LOAD_D = 3'd1;
    localparam logic [STATE_W-1:0] ST_LOAD_I = 3'd2;
    localparam logic [STATE_W-1:0] ST_FLUSH  = 3'd3;
    localparam logic [STATE_W-1:0] ST_RUN    = 3'd4;
    localparam logic [STATE_W-1:0] ST_HALT   = 3'd5;

    localparam int unsigned STAT_BUSY  = 0;
    localparam int unsigned STAT_DONE  = 1;
    localparam int unsigned STAT_ERROR = 2;
    localparam int unsigned STAT_W     = 3;

    // States during which the sequencer refuses a new start.
    function automatic logic is_busy_state(input logic [STATE_W-1:0] st);
        return st inside {ST_LOAD_D, ST_LOAD_I, ST_FLUSH, ST_RUN};
    endfunction

endpackage

// File: rtl/bram_stream_writer.sv
// Turns accepted host words into sequential registered BRAM writes; flags the last word.
module bram_stream_writer
    import boot_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned MAX_WORDS  = I_BRAM_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clear,
    input  logic                  s_valid,
    input  logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic [CNT_W-1:0]      count,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [DATA_WIDTH-1:0] w_dat,
    output logic                  w_enb,
    output logic                  last_c
);

    localparam int unsigned IDX_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

    logic [IDX_W-1:0] idx;
    logic             accept_c;

    assign accept_c = en & s_valid & s_ready;
    assign last_c   = accept_c & (CNT_W'(idx) == (count - CNT_W'(1)));

    // Word index and one-cycle-delayed write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx    <= '0;
            w_addr <= '0;
            w_dat  <= '0;
            w_enb  <= 1'b0;
        end else begin
            w_enb <= accept_c;
            if (accept_c) begin
                w_addr <= ADDR_WIDTH'({idx, 2'b00});
                w_dat  <= s_data;
            end
            if (clear || last_c) begin
                idx <= '0;
            end else if (accept_c) begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/boot_sequencer.sv
// Loads data then instruction BRAM from a host stream, then runs the core for a budget or until halted.
module boot_sequencer
    import boot_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned MAX_WORDS  = I_BRAM_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_W-1:0]      data_count,
    input  logic [CNT_W-1:0]      instr_count,
    input  logic [CYC_W-1:0]      run_cycles,
    input  logic                  halt_req,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic [ADDR_WIDTH-1:0] d_w_addr,
    output logic [DATA_WIDTH-1:0] d_w_dat,
    output logic                  d_w_enb,
    output logic [ADDR_WIDTH-1:0] i_w_addr,
    output logic [DATA_WIDTH-1:0] i_w_dat,
    output logic                  i_w_enb,
    output logic                  d_bram_init_done,
    output logic                  cpu_rst,
    output logic                  pc_stall,
    output logic                  i_r_enb,
    output logic                  rd_enbl,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [CYC_W-1:0]      cycle_count
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

    logic [STATE_W-1:0] state_q, state_nxt;
    logic [CNT_W-1:0]   d_cnt_q, d_cnt_nxt;
    logic [CNT_W-1:0]   i_cnt_q, i_cnt_nxt;
    logic [CYC_W-1:0]   cycle_nxt;
    logic [STAT_W-1:0]  status_q, status_nxt;
    logic               err_nxt;
    logic               init_done_nxt;
    logic               s_ready_nxt;
    logic               cpu_rst_nxt;
    logic               pc_stall_nxt;
    logic               run_en_nxt;
    logic               clear_c;
    logic               d_last_c;
    logic               i_last_c;

    assign busy  = status_q[STAT_BUSY];
    assign done  = status_q[STAT_DONE];
    assign error = status_q[STAT_ERROR];

    bram_stream_writer #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_WORDS  (MAX_WORDS)
    ) u_d_writer (
        .clk     (clk),
        .rst     (rst),
        .en      (state_q == ST_LOAD_D),
        .clear   (clear_c),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .count   (d_cnt_q),
        .w_addr  (d_w_addr),
        .w_dat   (d_w_dat),
        .w_enb   (d_w_enb),
        .last_c  (d_last_c)
    );

    bram_stream_writer #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_WORDS  (MAX_WORDS)
    ) u_i_writer (
        .clk     (clk),
        .rst     (rst),
        .en      (state_q == ST_LOAD_I),
        .clear   (clear_c),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .count   (i_cnt_q),
        .w_addr  (i_w_addr),
        .w_dat   (i_w_dat),
        .w_enb   (i_w_enb),
        .last_c  (i_last_c)
    );

    // Next state plus next value of every registered output.
    always_comb begin
        state_nxt     = state_q;
        d_cnt_nxt     = d_cnt_q;
        i_cnt_nxt     = i_cnt_q;
        cycle_nxt     = cycle_count;
        err_nxt       = status_q[STAT_ERROR];
        init_done_nxt = d_bram_init_done;
        clear_c       = 1'b0;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    if ((data_count > MAX_CNT) || (instr_count > MAX_CNT)) begin
                        err_nxt = 1'b1;
                    end else begin
                        err_nxt       = 1'b0;
                        cycle_nxt     = '0;
                        clear_c       = 1'b1;
                        init_done_nxt = 1'b0;
                        d_cnt_nxt     = data_count;
                        i_cnt_nxt     = instr_count;
                        if (data_count != '0) begin
                            state_nxt = ST_LOAD_D;
                        end else if (instr_count != '0) begin
                            state_nxt = ST_LOAD_I;
                        end else begin
                            state_nxt = ST_FLUSH;
                        end
                    end
                end
            end
            ST_LOAD_D: begin
                if (d_last_c) begin
                    state_nxt = (i_cnt_q == '0) ? ST_FLUSH : ST_LOAD_I;
                end
            end
            ST_LOAD_I: begin
                if (i_last_c) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_nxt     = ST_RUN;
                init_done_nxt = 1'b1;
            end
            ST_RUN: begin
                cycle_nxt = cycle_count + CYC_W'(1);
                if (halt_req || ((run_cycles != '0) && (cycle_nxt == run_cycles))) begin
                    state_nxt = ST_HALT;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        s_ready_nxt  = (state_nxt == ST_LOAD_D) || (state_nxt == ST_LOAD_I);
        cpu_rst_nxt  = !((state_nxt == ST_RUN) || (state_nxt == ST_HALT));
        pc_stall_nxt = (state_nxt != ST_RUN);
        run_en_nxt   = (state_nxt == ST_RUN);

        status_nxt             = '0;
        status_nxt[STAT_BUSY]  = is_busy_state(state_nxt);
        status_nxt[STAT_DONE]  = (state_nxt == ST_HALT);
        status_nxt[STAT_ERROR] = err_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= ST_IDLE;
            d_cnt_q          <= '0;
            i_cnt_q          <= '0;
            cycle_count      <= '0;
            status_q         <= '0;
            d_bram_init_done <= 1'b0;
            s_ready          <= 1'b0;
            cpu_rst          <= 1'b1;
            pc_stall         <= 1'b1;
            i_r_enb          <= 1'b0;
            rd_enbl          <= 1'b0;
        end else begin
            state_q          <= state_nxt;
            d_cnt_q          <= d_cnt_nxt;
            i_cnt_q          <= i_cnt_nxt;
            cycle_count      <= cycle_nxt;
            status_q         <= status_nxt;
            d_bram_init_done <= init_done_nxt;
            s_ready          <= s_ready_nxt;
            cpu_rst          <= cpu_rst_nxt;
            pc_stall         <= pc_stall_nxt;
            i_r_enb          <= run_en_nxt;
            rd_enbl          <= run_en_nxt;
        end
    end

endmodule

// File: tb/tb_boot_sequencer.sv
// Scoreboard bench for boot_sequencer: host stream, BRAM write order, run budget, halt and reset.
module tb_boot_sequencer;

    typedef struct packed {
        logic        port;
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [8:0]  data_count;
    logic [8:0]  instr_count;
    logic [31:0] run_cycles;
    logic        halt_req;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic [9:0]  d_w_addr;
    logic [31:0] d_w_dat;
    logic        d_w_enb;
    logic [9:0]  i_w_addr;
    logic [31:0] i_w_dat;
    logic        i_w_enb;
    logic        d_bram_init_done;
    logic        cpu_rst;
    logic        pc_stall;
    logic        i_r_enb;
    logic        rd_enbl;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] cycle_count;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          d_wr_cnt = 0;
    wr_t         sb[$];
    wr_t         mon_e;
    logic [31:0] words[$];
    logic [31:0] mem_d [0:255];
    logic [31:0] mem_i [0:255];
    logic [31:0] ref_d [0:255];
    logic [31:0] ref_i [0:255];

    boot_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .data_count       (data_count),
        .instr_count      (instr_count),
        .run_cycles       (run_cycles),
        .halt_req         (halt_req),
        .s_valid          (s_valid),
        .s_data           (s_data),
        .s_ready          (s_ready),
        .d_w_addr         (d_w_addr),
        .d_w_dat          (d_w_dat),
        .d_w_enb          (d_w_enb),
        .i_w_addr         (i_w_addr),
        .i_w_dat          (i_w_dat),
        .i_w_enb          (i_w_enb),
        .d_bram_init_done (d_bram_init_done),
        .cpu_rst          (cpu_rst),
        .pc_stall         (pc_stall),
        .i_r_enb          (i_r_enb),
        .rd_enbl          (rd_enbl),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .cycle_count      (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write monitor: pops the scoreboard and mirrors both BRAMs.
    always @(negedge clk) begin
        if (rst && (d_w_enb || i_w_enb)) begin
            check("dual_write", 128'(d_w_enb & i_w_enb), 128'(0));
            if (d_w_enb) d_wr_cnt++;
            if (sb.size() == 0) begin
                check("sb_underflow", 128'(sb.size()), 128'(1));
            end else begin
                mon_e = sb.pop_front();
                check("wr_port", 128'(i_w_enb), 128'(mon_e.port));
                if (i_w_enb) begin
                    check("i_addr", 128'(i_w_addr), 128'(mon_e.addr));
                    check("i_data", 128'(i_w_dat), 128'(mon_e.data));
                    mem_i[i_w_addr[9:2]] = i_w_dat;
                end else begin
                    check("d_addr", 128'(d_w_addr), 128'(mon_e.addr));
                    check("d_data", 128'(d_w_dat), 128'(mon_e.data));
                    mem_d[d_w_addr[9:2]] = d_w_dat;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check(tag, 128'({s_ready, d_w_enb, i_w_enb, d_bram_init_done, busy, done, error,
                         i_r_enb, rd_enbl, cpu_rst, pc_stall}), 128'(11'b000_0000_0011));
        check(tag, 128'({d_w_addr, d_w_dat, i_w_addr, i_w_dat, cycle_count}), 128'(0));
    endtask

    task automatic do_start(input logic [8:0] dc, input logic [8:0] ic, input logic [31:0] rc);
        data_count  = dc;
        instr_count = ic;
        run_cycles  = rc;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    // Host driver; pushes the expected BRAM write for every word it sees accepted.
    task automatic load_stream(input int nd, input int ni, input bit gaps, input int stop_after,
                               output int first_acc);
        int  k     = 0;
        int  guard = 0;
        bit  ph    = 1'b1;
        bit  acc;
        wr_t e;
        first_acc = -1;
        while (k < stop_after && guard < 400) begin
            s_valid = gaps ? ph : 1'b1;
            ph      = ~ph;
            s_data  = words[k];
            acc     = s_valid && s_ready;
            if (acc) begin
                e.port = (k >= nd);
                e.addr = 10'((k - (k >= nd ? nd : 0)) * 4);
                e.data = words[k];
                sb.push_back(e);
                if (first_acc < 0) first_acc = cyc;
            end
            tick();
            check("w_enb_follows_hs", 128'(d_w_enb | i_w_enb), 128'(acc));
            if (acc) k++;
            guard++;
        end
        check("load_progress", 128'(k), 128'(stop_after));
        if (stop_after == nd + ni) s_valid = 1'b0;
    endtask

    // Waits for RUN, checks core controls, then checks the run length against the budget.
    task automatic finish_run(input int budget, input bit poke_start, output int fall);
        int g = 0;
        while (cpu_rst && g < 50) begin
            tick();
            g++;
        end
        check("run_entered", 128'(cpu_rst), 128'(0));
        fall = cyc;
        check("run_ctrl", 128'({pc_stall, i_r_enb, rd_enbl, d_bram_init_done, busy}), 128'(5'b01111));
        g = 0;
        while (!done && g < 300) begin
            if (poke_start && g == 1) start = 1'b1;
            tick();
            start = 1'b0;
            if (poke_start && g == 1) check("start_ignored_in_run", 128'({s_ready, busy}), 128'(2'b01));
            g++;
        end
        check("run_length", 128'(cyc - fall), 128'(budget));
        check("halt_count", 128'(cycle_count), 128'(budget));
        check("halt_ctrl", 128'({pc_stall, cpu_rst, busy, done, d_bram_init_done}), 128'(5'b10011));
        check("sb_drained", 128'(sb.size()), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int fa;
        int fall;
        int g;
        int d_before;

        rst = 1'b0; start = 1'b0; data_count = '0; instr_count = '0; run_cycles = '0;
        halt_req = 1'b0; s_valid = 1'b0; s_data = '0;
        for (int i = 0; i < 256; i++) begin
            mem_d[i] = '0; mem_i[i] = '0;
        end
        tick(); tick();
        check_reset_vals("reset_held");
        rst = 1'b1;
        tick();
        check_reset_vals("reset_released");

        // Oversized count is rejected and the FSM stays idle.
        do_start(9'd3, 9'd257, 32'd7);
        check("bad_count", 128'({error, s_ready, busy, cpu_rst}), 128'(4'b1001));

        // Basic load and run with continuous valid.
        words.delete();
        words.push_back(32'd1); words.push_back(32'd2); words.push_back(32'd3);
        for (int i = 0; i < 7; i++) words.push_back(32'hA000_0000 + 32'(i));
        do_start(9'd3, 9'd7, 32'd7);
        check("good_start", 128'({error, s_ready, busy, d_bram_init_done}), 128'(4'b0110));
        load_stream(3, 7, 1'b0, 10, fa);
        check("s_ready_drop", 128'(s_ready), 128'(0));
        finish_run(7, 1'b1, fall);
        check("cpu_rst_fall_latency", 128'(fall - fa), 128'(11));
        for (int i = 0; i < 256; i++) begin
            ref_d[i] = mem_d[i]; ref_i[i] = mem_i[i];
            mem_d[i] = '0;       mem_i[i] = '0;
        end

        // Same image with host backpressure.
        do_start(9'd3, 9'd7, 32'd7);
        load_stream(3, 7, 1'b1, 10, fa);
        finish_run(7, 1'b0, fall);
        for (int i = 0; i < 3; i++) check("bp_mem_d", 128'(mem_d[i]), 128'(ref_d[i]));
        for (int i = 0; i < 7; i++) check("bp_mem_i", 128'(mem_i[i]), 128'(ref_i[i]));

        // No data words: instruction load starts immediately.
        words.delete();
        words.push_back(32'hDEAD_0001); words.push_back(32'hDEAD_0002);
        d_before = d_wr_cnt;
        do_start(9'd0, 9'd2, 32'd3);
        check("zero_data_start", 128'({s_ready, busy}), 128'(2'b11));
        load_stream(0, 2, 1'b0, 2, fa);
        finish_run(3, 1'b0, fall);
        check("no_d_writes", 128'(d_wr_cnt - d_before), 128'(0));
        check("zero_data_i0", 128'(mem_i[0]), 128'(32'hDEAD_0001));

        // Unlimited run ended by halt_req.
        words.delete();
        words.push_back($urandom); words.push_back($urandom);
        do_start(9'd1, 9'd1, 32'd0);
        load_stream(1, 1, 1'b0, 2, fa);
        g = 0;
        while (cpu_rst && g < 50) begin tick(); g++; end
        check("halt_run_entered", 128'(cpu_rst), 128'(0));
        g = 0;
        while (cycle_count != 32'd19 && g < 100) begin tick(); g++; end
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        check("halt_req_stop", 128'({done, pc_stall, cpu_rst, busy}), 128'(4'b1100));
        check("halt_req_count", 128'(cycle_count), 128'(20));
        tick();
        check("halt_stays", 128'({done, cycle_count}), 128'({1'b1, 32'd20}));

        // Restart from HALT, then reset during the second instruction word.
        words.delete();
        for (int i = 0; i < 4; i++) words.push_back($urandom);
        do_start(9'd1, 9'd3, 32'd0);
        check("restart_clear", 128'({cycle_count, d_bram_init_done, done, cpu_rst, busy}),
              128'({32'd0, 4'b0011}));
        load_stream(1, 3, 1'b0, 3, fa);
        check("mid_load_write", 128'({i_w_enb, i_w_addr}), 128'({1'b1, 10'd4}));
        rst = 1'b0;
        #1;
        check_reset_vals("async_reset");
        sb.delete();
        s_valid = 1'b0;
        #2;
        rst = 1'b1;
        tick();
        check_reset_vals("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
